// File: rtl/npc_resolve_if.sv
// Next-PC bus between the EX resolution block (master) and the PC device (slave).
// The package carries the PCSrc encoding shared by both ends.
package npc_resolve_pkg;
    typedef enum logic [1:0] {
        PCSRC_PC4 = 2'd0,
        PCSRC_BR  = 2'd1,
        PCSRC_J   = 2'd2,
        PCSRC_JR  = 2'd3
    } pcsrc_t;

    typedef enum logic [2:0] {
        CTL_NONE = 3'd0,
        CTL_BEQ  = 3'd1,
        CTL_BNE  = 3'd2,
        CTL_J    = 3'd3,
        CTL_JAL  = 3'd4,
        CTL_JR   = 3'd5
    } ctl_t;
endpackage

interface npc_resolve_if;
    import npc_resolve_pkg::*;

    pcsrc_t      PCSrc;
    logic        zero;
    logic [31:0] pc_4;
    logic [31:0] b_addr;
    logic [31:0] j_addr;
    logic [31:0] jr_addr;
    logic [31:0] link_addr;
    logic        pc_control;

    modport master (
        output PCSrc, zero, pc_4, b_addr, j_addr, jr_addr, link_addr,
        input  pc_control
    );

    modport slave (
        input  PCSrc, zero, pc_4, b_addr, j_addr, jr_addr, link_addr,
        output pc_control
    );
endinterface

// File: rtl/npc_resolve.sv
// EX-stage branch/jump resolution: registers ID operands, computes targets and the
// branch condition, drives the next-PC bus, and masks the wrong-path shadow cycle.
module npc_resolve
    import npc_resolve_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             id_valid,
    input  logic [2:0]       id_ctl,
    input  logic [31:0]      id_pc_4,
    input  logic [15:0]      id_imm,
    input  logic [25:0]      id_jidx,
    input  logic [31:0]      id_rs,
    input  logic [31:0]      id_rt,
    input  logic             ex_stall,
    npc_resolve_if.master    npc,
    output logic             flush,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] tkn_cnt
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        ex_valid;
    ctl_t        ex_ctl;
    ctl_t        id_cls;
    logic [31:0] ex_pc_4;
    logic [15:0] ex_imm;
    logic [25:0] ex_jidx;
    logic [31:0] ex_rs;
    logic [31:0] ex_rt;

    pcsrc_t      kind;
    logic        cond;
    logic        live;
    logic        redirect_now;
    logic        resolve_br;

    always_comb begin
        id_cls = CTL_NONE;
        case (id_ctl)
            3'd1:    id_cls = CTL_BEQ;
            3'd2:    id_cls = CTL_BNE;
            3'd3:    id_cls = CTL_J;
            3'd4:    id_cls = CTL_JAL;
            3'd5:    id_cls = CTL_JR;
            default: id_cls = CTL_NONE;
        endcase
    end

    // In SQUASH the EX register takes a bubble; data fields still follow ID.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ex_valid <= 1'b0;
            ex_ctl   <= CTL_NONE;
            ex_pc_4  <= '0;
            ex_imm   <= '0;
            ex_jidx  <= '0;
            ex_rs    <= '0;
            ex_rt    <= '0;
        end else if (!ex_stall) begin
            ex_valid <= id_valid && (state_q == ST_RUN);
            ex_ctl   <= (state_q == ST_RUN) ? id_cls : CTL_NONE;
            ex_pc_4  <= id_pc_4;
            ex_imm   <= id_imm;
            ex_jidx  <= id_jidx;
            ex_rs    <= id_rs;
            ex_rt    <= id_rt;
        end
    end

    always_comb begin
        kind = PCSRC_PC4;
        case (ex_ctl)
            CTL_BEQ, CTL_BNE: kind = PCSRC_BR;
            CTL_J, CTL_JAL:   kind = PCSRC_J;
            CTL_JR:           kind = PCSRC_JR;
            default:          kind = PCSRC_PC4;
        endcase
    end

    assign cond = ((ex_ctl == CTL_BEQ) && (ex_rs == ex_rt)) ||
                  ((ex_ctl == CTL_BNE) && (ex_rs != ex_rt));

    assign live         = ex_valid && !ex_stall && (state_q == ST_RUN);
    assign redirect_now = live && (kind != PCSRC_PC4) && npc.pc_control;
    assign resolve_br   = live && (kind == PCSRC_BR);

    assign npc.PCSrc     = live ? kind : PCSRC_PC4;
    assign npc.zero      = live && cond;
    assign npc.pc_4      = ex_pc_4;
    assign npc.b_addr    = ex_pc_4 + {{14{ex_imm[15]}}, ex_imm, 2'b00};
    assign npc.j_addr    = {ex_pc_4[31:28], ex_jidx, 2'b00};
    assign npc.jr_addr   = ex_rs;
    assign npc.link_addr = ex_pc_4;
    assign flush         = redirect_now;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (redirect_now) state_d = ST_SQUASH;
            ST_SQUASH: if (!ex_stall)    state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            br_cnt  <= '0;
            tkn_cnt <= '0;
        end else begin
            if (resolve_br && (br_cnt != '1)) begin
                br_cnt <= br_cnt + CNT_W'(1);
            end
            if (redirect_now && (tkn_cnt != '1)) begin
                tkn_cnt <= tkn_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_npc_resolve.sv
// Bench for npc_resolve: directed scenarios then random traffic, every cycle compared
// against a behavioural model of the EX slot, shadow cycle and counters.
module tb_npc_resolve;
    import npc_resolve_pkg::*;

    localparam logic [2:0] C_NONE = 3'd0;
    localparam logic [2:0] C_BEQ  = 3'd1;
    localparam logic [2:0] C_BNE  = 3'd2;
    localparam logic [2:0] C_J    = 3'd3;
    localparam logic [2:0] C_JAL  = 3'd4;
    localparam logic [2:0] C_JR   = 3'd5;

    logic        CLK;
    logic        RST;
    logic        id_valid;
    logic [2:0]  id_ctl;
    logic [31:0] id_pc_4;
    logic [15:0] id_imm;
    logic [25:0] id_jidx;
    logic [31:0] id_rs;
    logic [31:0] id_rt;
    logic        ex_stall;
    logic        pcc;
    logic        flush, s_flush;
    logic [31:0] br_cnt, tkn_cnt;
    logic [1:0]  s_br_cnt, s_tkn_cnt;

    npc_resolve_if bus ();
    npc_resolve_if sbus ();

    assign bus.pc_control  = pcc;
    assign sbus.pc_control = pcc;

    npc_resolve #(.CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_ctl(id_ctl), .id_pc_4(id_pc_4),
        .id_imm(id_imm), .id_jidx(id_jidx), .id_rs(id_rs), .id_rt(id_rt),
        .ex_stall(ex_stall), .npc(bus.master), .flush(flush),
        .br_cnt(br_cnt), .tkn_cnt(tkn_cnt)
    );

    npc_resolve #(.CNT_W(2)) dut_sat (
        .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_ctl(id_ctl), .id_pc_4(id_pc_4),
        .id_imm(id_imm), .id_jidx(id_jidx), .id_rs(id_rs), .id_rt(id_rt),
        .ex_stall(ex_stall), .npc(sbus.master), .flush(s_flush),
        .br_cnt(s_br_cnt), .tkn_cnt(s_tkn_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Model: contents of the EX slot, whether we are in the shadow after a redirect,
    // and unbounded event counts (saturation applied when comparing).
    logic        m_valid;
    int          m_ctl;
    logic [31:0] m_pc4, m_rs, m_rt;
    logic [15:0] m_imm;
    logic [25:0] m_jidx;
    logic        m_shadow;
    longint      m_br, m_tkn;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic pcsrc_t class_of(input int ctl);
        if (ctl == 1 || ctl == 2) return PCSRC_BR;
        if (ctl == 3 || ctl == 4) return PCSRC_J;
        if (ctl == 5)             return PCSRC_JR;
        return PCSRC_PC4;
    endfunction

    function automatic longint sat(input longint c, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (c > mx) ? mx : c;
    endfunction

    function automatic logic m_live();
        return m_valid && !ex_stall && !m_shadow;
    endfunction

    task automatic check_model();
        pcsrc_t      e_src;
        logic        e_zero, e_flush;
        int          simm;
        logic [31:0] e_b, e_j;
        e_src   = m_live() ? class_of(m_ctl) : PCSRC_PC4;
        e_zero  = m_live() && ((m_ctl == 1 && m_rs == m_rt) || (m_ctl == 2 && m_rs != m_rt));
        e_flush = (e_src != PCSRC_PC4) && pcc;
        simm    = $signed(m_imm);
        e_b     = m_pc4 + 32'(simm * 4);
        e_j     = (m_pc4 & 32'hF000_0000) + (32'(m_jidx) * 32'd4);
        check("pcsrc",   64'(bus.PCSrc),     64'(e_src));
        check("zero",    64'(bus.zero),      64'(e_zero));
        check("flush",   64'(flush),         64'(e_flush));
        check("pc_4",    64'(bus.pc_4),      64'(m_pc4));
        check("b_addr",  64'(bus.b_addr),    64'(e_b));
        check("j_addr",  64'(bus.j_addr),    64'(e_j));
        check("jr_addr", 64'(bus.jr_addr),   64'(m_rs));
        check("link",    64'(bus.link_addr), 64'(m_pc4));
        check("br_cnt",  64'(br_cnt),        64'(sat(m_br, 32)));
        check("tkn_cnt", 64'(tkn_cnt),       64'(sat(m_tkn, 32)));
        check("s_flush", 64'(s_flush),       64'(e_flush));
        check("s_br",    64'(s_br_cnt),      64'(sat(m_br, 2)));
        check("s_tkn",   64'(s_tkn_cnt),     64'(sat(m_tkn, 2)));
    endtask

    task automatic drive(input logic rst, input logic v, input logic [2:0] ctl,
                         input logic [31:0] pc4, input logic [15:0] imm,
                         input logic [25:0] jidx, input logic [31:0] rs,
                         input logic [31:0] rt, input logic stall, input logic pc_ctl);
        @(negedge CLK);
        RST = rst; id_valid = v; id_ctl = ctl; id_pc_4 = pc4; id_imm = imm;
        id_jidx = jidx; id_rs = rs; id_rt = rt; ex_stall = stall; pcc = pc_ctl;
        #1;
    endtask

    task automatic tick();
        logic   live, fl;
        pcsrc_t k;
        @(posedge CLK);
        live = m_live();
        k    = class_of(m_ctl);
        fl   = live && (k != PCSRC_PC4) && pcc;
        if (RST) begin
            m_valid = 1'b0; m_ctl = 0; m_pc4 = '0; m_imm = '0; m_jidx = '0;
            m_rs = '0; m_rt = '0; m_shadow = 1'b0; m_br = 0; m_tkn = 0;
        end else begin
            if (live && k == PCSRC_BR) m_br++;
            if (fl) m_tkn++;
            if (!ex_stall) begin
                m_valid = id_valid && !m_shadow;
                m_ctl   = m_shadow ? 0 : int'(id_ctl);
                m_pc4 = id_pc_4; m_imm = id_imm; m_jidx = id_jidx; m_rs = id_rs; m_rt = id_rt;
            end
            m_shadow = fl ? 1'b1 : (m_shadow && ex_stall);
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic [2:0] ctl,
                        input logic [31:0] pc4, input logic [15:0] imm,
                        input logic [25:0] jidx, input logic [31:0] rs,
                        input logic [31:0] rt, input logic stall, input logic pc_ctl);
        drive(rst, v, ctl, pc4, imm, jidx, rs, rt, stall, pc_ctl);
        check_model();
        tick();
    endtask

    task automatic idle(input logic pc_ctl);
        step(1'b0, 1'b0, C_NONE, '0, '0, '0, '0, '0, 1'b0, pc_ctl);
    endtask

    task automatic taken_branch();
        step(1'b0, 1'b1, C_BEQ, 32'h100, 16'h0004, '0, 32'd9, 32'd9, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; id_valid = 1'b0; id_ctl = '0; id_pc_4 = '0; id_imm = '0;
        id_jidx = '0; id_rs = '0; id_rt = '0; ex_stall = 1'b0; pcc = 1'b0;

        // Reset while ID presents a valid BEQ; state before this edge is unknown.
        drive(1'b1, 1'b1, C_BEQ, 32'h104, 16'hFFFF, '0, 32'd5, 32'd5, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b1, C_BEQ, 32'h0000_0104, 16'hFFFF, '0, 32'd5, 32'd5, 1'b0, 1'b0);
        check_model();
        check("rst_pcsrc", 64'(bus.PCSrc), 64'(PCSRC_PC4));
        check("rst_br",    64'(br_cnt),    64'd0);
        tick();

        // BEQ taken, redirected by the PC device; next cycle is the shadow.
        drive(1'b0, 1'b1, C_J, 32'h200, '0, 26'h1, '0, '0, 1'b0, 1'b1);
        check_model();
        check("beq_b_addr", 64'(bus.b_addr), 64'h100);
        check("beq_zero",   64'(bus.zero),   64'd1);
        check("beq_flush",  64'(flush),      64'd1);
        tick();
        drive(1'b0, 1'b1, C_J, 32'h300, '0, 26'h2, '0, '0, 1'b0, 1'b1);
        check_model();
        check("shadow_pcsrc", 64'(bus.PCSrc), 64'(PCSRC_PC4));
        check("shadow_tkn",   64'(tkn_cnt),   64'd1);
        tick();

        // BNE with equal operands is not taken.
        step(1'b0, 1'b1, C_BNE, 32'h400, 16'h0010, '0, 32'd7, 32'd7, 1'b0, 1'b0);
        drive(1'b0, 1'b0, C_NONE, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        check_model();
        check("bne_zero", 64'(bus.zero), 64'd0);
        tick();

        // J, JR, JAL back to back.
        step(1'b0, 1'b1, C_J, 32'hA000_0008, '0, 26'h0000010, '0, '0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, C_JR, 32'h8, '0, '0, 32'h0040_0020, '0, 1'b0, 1'b0);
        check_model();
        check("j_addr", 64'(bus.j_addr), 64'hA000_0040);
        tick();
        drive(1'b0, 1'b1, C_JAL, 32'hA000_0008, '0, 26'h5, '0, '0, 1'b0, 1'b0);
        check_model();
        check("jr_addr",  64'(bus.jr_addr), 64'h0040_0020);
        check("jr_pcsrc", 64'(bus.PCSrc),   64'(PCSRC_JR));
        tick();
        drive(1'b0, 1'b0, C_NONE, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        check_model();
        check("jal_link", 64'(bus.link_addr), 64'hA000_0008);
        tick();

        // JR held in EX by a 3-cycle stall with pc_control asserted throughout.
        step(1'b0, 1'b1, C_JR, 32'h500, '0, '0, 32'h1234_5678, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, C_BEQ, 32'h600, '0, '0, '0, '0, 1'b1, 1'b1);
            check_model();
            check("stall_flush", 64'(flush), 64'd0);
            tick();
        end
        drive(1'b0, 1'b1, C_BEQ, 32'h600, '0, '0, '0, '0, 1'b0, 1'b1);
        check_model();
        check("unstall_flush", 64'(flush), 64'd1);
        tick();
        idle(1'b1);
        idle(1'b0);

        // Saturation of the narrow counters, then reset in the middle of SQUASH.
        step(1'b1, 1'b0, C_NONE, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) taken_branch();
        drive(1'b0, 1'b0, C_NONE, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        check_model();
        check("sat_tkn", 64'(s_tkn_cnt), 64'd3);
        check("wide_tkn", 64'(tkn_cnt), 64'd4);
        tick();
        step(1'b0, 1'b1, C_BEQ, 32'h100, 16'h0004, '0, 32'd1, 32'd1, 1'b0, 1'b0);
        idle(1'b1);
        step(1'b1, 1'b1, C_JR, 32'h700, '0, '0, 32'hBEEF, '0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, C_JR, 32'h700, '0, '0, 32'hBEEF, '0, 1'b0, 1'b0);
        check_model();
        check("rst_sq_tkn", 64'(tkn_cnt), 64'd0);
        tick();
        drive(1'b0, 1'b0, C_NONE, '0, '0, '0, '0, '0, 1'b0, 1'b1);
        check_model();
        check("rst_sq_run", 64'(flush), 64'd1);
        tick();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rs, rt;
            rs = $urandom();
            rt = ($urandom_range(0, 1) == 1) ? rs : 32'($urandom());
            step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) != 0),
                 3'($urandom_range(0, 7)), 32'($urandom()), 16'($urandom()),
                 26'($urandom()), rs, rt, ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
